// File: rtl/enc_ctrl_fsm.sv
// Encoder control FSM: sequences record, data, and tail phases of one block and drives datapath enables.
// Optional build macro ENC_CTRL_ABORT_EN adds an abort input that returns the FSM to INIT.
module enc_ctrl_fsm #(
  parameter int LEN_W     = 12,
  parameter int TAIL_LEN  = 3,
  parameter int VALID_DLY = 1
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             cbs_ready,
  input  logic             int_ready,
  input  logic             out_ready,
  input  logic [LEN_W-1:0] blk_len,
`ifdef ENC_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             record_en,
  output logic             delay_wen,
  output logic             delay_ren,
  output logic             counter_en,
  output logic             close_switch,
  output logic             tail_en,
  output logic             tail_mode,
  output logic             enc_en,
  output logic             tail_counter_enable,
  output logic             ready,
  output logic             out_valid,
  output logic             blk_done,
  output logic [2:0]       state,
  output logic [LEN_W-1:0] data_cnt
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0, S_RECORD = 3'd1, S_WAIT_INT = 3'd2, S_OPERATE = 3'd3,
    S_LAST_OPERATE = 3'd4, S_TAIL = 3'd5, S_WAIT_TAIL = 3'd6, S_LAST_TAIL = 3'd7
  } state_t;

  state_t                 r_state, w_nxt;
  logic [LEN_W-1:0]       r_len_q, r_data_cnt;
  logic [3:0]             r_tail_cnt;
  logic [VALID_DLY-1:0]   r_vld_pipe;
  logic                   w_run, w_adv, w_abort;

`ifdef ENC_CTRL_ABORT_EN
  assign w_abort = abort && (r_state != S_INIT);
`else
  assign w_abort = 1'b0;
`endif

  // Encoding states only move forward when downstream accepts.
  assign w_run = (r_state == S_OPERATE) || (r_state == S_LAST_OPERATE) ||
                 (r_state == S_TAIL)    || (r_state == S_WAIT_TAIL);
  assign w_adv = w_run && out_ready;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_INIT:         if (cbs_ready) w_nxt = S_RECORD;
      S_RECORD:       w_nxt = S_WAIT_INT;
      S_WAIT_INT:     if (int_ready) w_nxt = S_OPERATE;
      S_OPERATE:      if (w_adv && r_data_cnt == r_len_q - LEN_W'(2)) w_nxt = S_LAST_OPERATE;
      S_LAST_OPERATE: if (w_adv) w_nxt = S_TAIL;
      S_TAIL:         if (w_adv) w_nxt = S_WAIT_TAIL;
      S_WAIT_TAIL:    if (w_adv && r_tail_cnt == 4'(TAIL_LEN - 1)) w_nxt = S_LAST_TAIL;
      S_LAST_TAIL:    w_nxt = S_INIT;
      default:        w_nxt = S_INIT;
    endcase
    if (w_abort) w_nxt = S_INIT;
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) r_state <= S_INIT;
    else         r_state <= w_nxt;
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_len_q    <= '0;
      r_data_cnt <= '0;
      r_tail_cnt <= '0;
    end else if (w_abort) begin
      r_data_cnt <= '0;
      r_tail_cnt <= '0;
    end else begin
      case (r_state)
        S_RECORD: begin
          r_data_cnt <= '0;
          // Blocks shorter than 2 bits still need one OPERATE and one LAST_OPERATE cycle.
          r_len_q    <= (blk_len < LEN_W'(2)) ? LEN_W'(2) : blk_len;
        end
        S_OPERATE: if (w_adv) r_data_cnt <= r_data_cnt + LEN_W'(1);
        S_LAST_OPERATE: begin
          r_tail_cnt <= '0;
          if (w_adv) r_data_cnt <= r_data_cnt + LEN_W'(1);
        end
        S_TAIL, S_WAIT_TAIL: if (w_adv) r_tail_cnt <= r_tail_cnt + 4'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) r_vld_pipe <= '0;
    else begin
      r_vld_pipe[0] <= enc_en;
      for (int i = 1; i < VALID_DLY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  always_comb begin
    record_en           = (r_state == S_RECORD);
    delay_wen           = (r_state == S_RECORD) || (r_state == S_WAIT_INT) ||
                          (r_state == S_OPERATE) || (r_state == S_LAST_OPERATE);
    delay_ren           = (r_state == S_OPERATE) && out_ready;
    tail_en             = (r_state == S_LAST_OPERATE);
    counter_en          = ((r_state == S_OPERATE) || (r_state == S_LAST_OPERATE)) && out_ready;
    close_switch        = (r_state == S_LAST_OPERATE) || (r_state == S_TAIL) ||
                          (r_state == S_WAIT_TAIL);
    tail_mode           = (r_state == S_TAIL) || (r_state == S_WAIT_TAIL) ||
                          (r_state == S_LAST_TAIL);
    tail_counter_enable = close_switch;
    ready               = (r_state == S_INIT);
    blk_done            = (r_state == S_LAST_TAIL);
    enc_en              = w_adv;
  end

  assign out_valid = r_vld_pipe[VALID_DLY-1];
  assign state     = r_state;
  assign data_cnt  = r_data_cnt;

endmodule

// File: tb/tb_enc_ctrl_fsm.sv
// Directed bench for enc_ctrl_fsm: a default instance plus a VALID_DLY=3 instance share stimulus.
module tb_enc_ctrl_fsm;
  localparam int LEN_W = 12;

  logic clock = 1'b0, aclr_n = 1'b0;
  logic cbs_ready = 1'b0, int_ready = 1'b0, out_ready = 1'b0;
  logic [LEN_W-1:0] blk_len = '0;
`ifdef ENC_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  logic record_en, delay_wen, delay_ren, counter_en, close_switch, tail_en, tail_mode;
  logic enc_en, tail_counter_enable, ready, out_valid, blk_done;
  logic [2:0] state;
  logic [LEN_W-1:0] data_cnt;

  logic record_en3, delay_wen3, delay_ren3, counter_en3, close_switch3, tail_en3, tail_mode3;
  logic enc_en3, tail_counter_enable3, ready3, out_valid3, blk_done3;
  logic [2:0] state3;
  logic [LEN_W-1:0] data_cnt3;
  logic unused3;
  assign unused3 = ^{record_en3, delay_wen3, delay_ren3, counter_en3, close_switch3, tail_en3,
                     tail_mode3, enc_en3, tail_counter_enable3, ready3, blk_done3, state3, data_cnt3,
                     record_en, delay_wen, delay_ren, counter_en, close_switch, tail_en, tail_mode,
                     tail_counter_enable};

  enc_ctrl_fsm #(.LEN_W(LEN_W), .TAIL_LEN(3), .VALID_DLY(1)) dut (
    .clock(clock), .aclr_n(aclr_n), .cbs_ready(cbs_ready), .int_ready(int_ready),
    .out_ready(out_ready), .blk_len(blk_len),
`ifdef ENC_CTRL_ABORT_EN
    .abort(abort),
`endif
    .record_en(record_en), .delay_wen(delay_wen), .delay_ren(delay_ren),
    .counter_en(counter_en), .close_switch(close_switch), .tail_en(tail_en),
    .tail_mode(tail_mode), .enc_en(enc_en), .tail_counter_enable(tail_counter_enable),
    .ready(ready), .out_valid(out_valid), .blk_done(blk_done), .state(state),
    .data_cnt(data_cnt));

  enc_ctrl_fsm #(.LEN_W(LEN_W), .TAIL_LEN(3), .VALID_DLY(3)) dut3 (
    .clock(clock), .aclr_n(aclr_n), .cbs_ready(cbs_ready), .int_ready(int_ready),
    .out_ready(out_ready), .blk_len(blk_len),
`ifdef ENC_CTRL_ABORT_EN
    .abort(abort),
`endif
    .record_en(record_en3), .delay_wen(delay_wen3), .delay_ren(delay_ren3),
    .counter_en(counter_en3), .close_switch(close_switch3), .tail_en(tail_en3),
    .tail_mode(tail_mode3), .enc_en(enc_en3), .tail_counter_enable(tail_counter_enable3),
    .ready(ready3), .out_valid(out_valid3), .blk_done(blk_done3), .state(state3),
    .data_cnt(data_cnt3));

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int n_en, first_en, last_en, n_gap, n_done, done_idx, last_wt, n_op, n_lo;
  int n_ov, first_ov, last_ov, first_ov3, last_ov3, end_cnt, ab_state, ab_cnt;
  int st0, st1, st2;
  bit hold_ok;

  // Starts one block from INIT and samples every cycle; cycle 0 is RECORD.
  task automatic run_block(input int len, input int st_s, input int st_n, input int ab_at,
                           input int ncyc);
    logic [2:0] p_state;
    logic [LEN_W-1:0] p_cnt;
    n_en = 0; first_en = -1; last_en = -1; n_done = 0; done_idx = -1; last_wt = -1;
    n_op = 0; n_lo = 0; n_ov = 0; first_ov = -1; last_ov = -1; first_ov3 = -1; last_ov3 = -1;
    ab_state = -1; ab_cnt = -1; hold_ok = 1'b1; st0 = -1; st1 = -1; st2 = -1;
    p_state = '0; p_cnt = '0;
    blk_len = LEN_W'(len); cbs_ready = 1'b1; int_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clock); #1;
      cbs_ready = 1'b0;
      if (i >= 1) blk_len = 12'hA5A;
      out_ready = !(i >= st_s && i < st_s + st_n);
`ifdef ENC_CTRL_ABORT_EN
      abort = (i == ab_at);
`endif
      #1;
      if (i == 0) st0 = int'(state);
      if (i == 1) st1 = int'(state);
      if (i == 2) st2 = int'(state);
      if (enc_en) begin
        if (first_en < 0) first_en = i;
        last_en = i; n_en++;
      end
      if (out_valid) begin
        if (first_ov < 0) first_ov = i;
        last_ov = i; n_ov++;
      end
      if (out_valid3) begin
        if (first_ov3 < 0) first_ov3 = i;
        last_ov3 = i;
      end
      if (blk_done) begin n_done++; done_idx = i; end
      if (state == 3'd6) last_wt = i;
      if (state == 3'd3) n_op++;
      if (state == 3'd4) n_lo++;
      if (i > st_s && i <= st_s + st_n && (state != p_state || data_cnt != p_cnt)) hold_ok = 1'b0;
      if (i == ab_at + 1) begin ab_state = int'(state); ab_cnt = int'(data_cnt); end
      p_state = state; p_cnt = data_cnt;
    end
`ifdef ENC_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    end_cnt = int'(data_cnt);
    n_gap = (first_en < 0) ? -1 : (last_en - first_en + 1 - n_en);
  endtask

  task automatic test_reset();
    aclr_n = 1'b0; #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
    checks++; if (data_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", data_cnt); end
    checks++; if (out_valid !== 1'b0 || blk_done !== 1'b0) begin errors++; $display("FAIL reset_flags: got ov=%b done=%b exp 0 0", out_valid, blk_done); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", ready); end
    repeat (2) @(posedge clock);
    #1 aclr_n = 1'b1;
    @(posedge clock); #2;
    checks++; if (state !== 3'd0 || ready !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got state=%0d ready=%b exp 0 1", state, ready); end
  endtask

  task automatic test_normal();
    run_block(8, 100, 0, 100, 24);
    checks++; if (st0 != 1 || st1 != 2 || st2 != 3) begin errors++; $display("FAIL entry_seq: got %0d %0d %0d exp 1 2 3", st0, st1, st2); end
    checks++; if (n_en != 11) begin errors++; $display("FAIL norm_enc_cycles: got %0d exp 11", n_en); end
    checks++; if (n_gap != 0 || first_en != 2) begin errors++; $display("FAIL norm_enc_contig: got gap=%0d first=%0d exp 0 2", n_gap, first_en); end
    checks++; if (end_cnt != 8) begin errors++; $display("FAIL norm_data_cnt: got %0d exp 8", end_cnt); end
    checks++; if (n_done != 1 || done_idx != last_wt + 1 || done_idx != 13) begin errors++; $display("FAIL norm_blk_done: got n=%0d idx=%0d wt=%0d exp 1 13 12", n_done, done_idx, last_wt); end
    checks++; if (n_op != 7 || n_lo != 1) begin errors++; $display("FAIL norm_op_cycles: got op=%0d lo=%0d exp 7 1", n_op, n_lo); end
    checks++; if (n_ov != 11 || first_ov != 3 || last_ov != 13) begin errors++; $display("FAIL norm_out_valid: got n=%0d first=%0d last=%0d exp 11 3 13", n_ov, first_ov, last_ov); end
  endtask

  task automatic test_valid_dly();
    run_block(8, 100, 0, 100, 24);
    checks++; if (first_ov3 != first_en + 3) begin errors++; $display("FAIL dly3_rise: got %0d exp %0d", first_ov3, first_en + 3); end
    checks++; if (last_ov3 != last_en + 3) begin errors++; $display("FAIL dly3_fall: got %0d exp %0d", last_ov3, last_en + 3); end
  endtask

  task automatic test_stall();
    run_block(8, 4, 4, 100, 30);
    checks++; if (!hold_ok) begin errors++; $display("FAIL stall_hold: got changed exp held"); end
    checks++; if (n_en != 11 || n_gap != 4) begin errors++; $display("FAIL stall_enc: got n=%0d gap=%0d exp 11 4", n_en, n_gap); end
    checks++; if (last_en != 16 || end_cnt != 8 || n_done != 1) begin errors++; $display("FAIL stall_end: got last=%0d cnt=%0d done=%0d exp 16 8 1", last_en, end_cnt, n_done); end
  endtask

  task automatic test_short_len();
    run_block(0, 100, 0, 100, 20);
    checks++; if (n_op != 1 || n_lo != 1) begin errors++; $display("FAIL len0_op: got op=%0d lo=%0d exp 1 1", n_op, n_lo); end
    checks++; if (n_en != 5 || end_cnt != 2) begin errors++; $display("FAIL len0_enc: got n=%0d cnt=%0d exp 5 2", n_en, end_cnt); end
  endtask

  task automatic test_reset_mid_block();
    bit found = 1'b0;
    blk_len = 12'd8; cbs_ready = 1'b1; int_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clock); #1;
      cbs_ready = 1'b0;
      #1;
      if (state == 3'd6) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL reach_wait_tail: got timeout exp state 6"); end
    aclr_n = 1'b0; #1;
    checks++; if (state !== 3'd0 || ready !== 1'b1 || data_cnt !== '0 || enc_en !== 1'b0) begin errors++; $display("FAIL async_reset: got st=%0d rdy=%b cnt=%0d en=%b exp 0 1 0 0", state, ready, data_cnt, enc_en); end
    #1 aclr_n = 1'b1;
    @(posedge clock); #2;
    run_block(5, 100, 0, 100, 20);
    checks++; if (n_en != 8 || n_done != 1 || end_cnt != 5) begin errors++; $display("FAIL after_reset_blk: got n=%0d done=%0d cnt=%0d exp 8 1 5", n_en, n_done, end_cnt); end
  endtask

`ifdef ENC_CTRL_ABORT_EN
  task automatic test_abort();
    run_block(8, 100, 0, 5, 20);
    checks++; if (ab_state != 0 || ab_cnt != 0) begin errors++; $display("FAIL abort_init: got st=%0d cnt=%0d exp 0 0", ab_state, ab_cnt); end
    checks++; if (n_done != 0) begin errors++; $display("FAIL abort_done: got %0d exp 0", n_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_valid_dly();
    test_stall();
    test_short_len();
    test_reset_mid_block();
`ifdef ENC_CTRL_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/enc_ctrl_fsm.md
ENC_CTRL_FSM -- requirements
Module: enc_ctrl_fsm

Interface
REQ-001 Parameter LEN_W, default 12: width of the block-length input and the internal data counter.
REQ-002 Parameter TAIL_LEN, default 3: number of tail encoder cycles; legal range 2..15.
REQ-003 Parameter VALID_DLY, default 1: out_valid latency after enc_en, in cycles; legal range 1..4.
REQ-004 Port clock  in  1  single clock; all registers are clocked on the rising edge.
REQ-005 Port aclr_n  in  1  asynchronous, active-low reset.
REQ-006 Port cbs_ready  in  1  a new block is available for recording.
REQ-007 Port int_ready  in  1  the interleaver is ready.
REQ-008 Port out_ready  in  1  downstream can accept; low stalls encoding.
REQ-009 Port blk_len  in  LEN_W  block length in bits; sampled only in RECORD.
REQ-010 Ports record_en, delay_wen, delay_ren, counter_en, close_switch, tail_en, tail_mode, enc_en, tail_counter_enable, ready  out  1 each  datapath controls.
REQ-011 Port out_valid  out  1  registered output-valid flag.
REQ-012 Port blk_done  out  1  one-cycle pulse at the end of a block.
REQ-013 Port state  out  3  current state encoding.
REQ-014 Port data_cnt  out  LEN_W  number of data bits encoded in the current block.

Function
REQ-015 States and encodings: INIT=0, RECORD=1, WAIT_INT=2, OPERATE=3, LAST_OPERATE=4, TAIL=5, WAIT_TAIL=6, LAST_TAIL=7.
REQ-016 Transitions:
- INIT -> RECORD when cbs_ready is high.
- RECORD -> WAIT_INT unconditionally.
- WAIT_INT -> OPERATE when int_ready is high.
- OPERATE -> LAST_OPERATE on the advance cycle where data_cnt == len_q-2.
- LAST_OPERATE -> TAIL on advance.
- TAIL -> WAIT_TAIL on advance.
- WAIT_TAIL -> LAST_TAIL on the advance where tail_cnt == TAIL_LEN-1.
- LAST_TAIL -> INIT unconditionally.
REQ-017 Advance: in OPERATE, LAST_OPERATE, TAIL and WAIT_TAIL, the state and both counters move only when out_ready is high; otherwise they hold.
REQ-018 RECORD latches len_q = blk_len; if blk_len < 2, len_q is set to 2.
REQ-019 data_cnt:
- cleared in RECORD;
- incremented on each advance in OPERATE and LAST_OPERATE;
- equals len_q after LAST_OPERATE.
REQ-020 tail_cnt (internal, 4 bits):
- cleared in LAST_OPERATE;
- incremented on each advance in TAIL and WAIT_TAIL.
REQ-021 Decodes:
- record_en = RECORD.
- delay_wen = RECORD, WAIT_INT, OPERATE or LAST_OPERATE.
- delay_ren = OPERATE and out_ready.
- tail_en = LAST_OPERATE.
- counter_en = (OPERATE or LAST_OPERATE) and out_ready.
- close_switch = LAST_OPERATE, TAIL or WAIT_TAIL.
- tail_mode = TAIL, WAIT_TAIL or LAST_TAIL.
- tail_counter_enable = LAST_OPERATE, TAIL or WAIT_TAIL.
- ready = INIT.
- blk_done = LAST_TAIL.
REQ-022 enc_en = (OPERATE, LAST_OPERATE, TAIL or WAIT_TAIL) and out_ready.
REQ-023 out_valid equals enc_en delayed by exactly VALID_DLY clocks, through a shift register.
REQ-024 Encoder cycles per block = len_q + TAIL_LEN, independent of stalls.
REQ-025 In INIT, cbs_ready high together with int_ready high still passes through RECORD and WAIT_INT; WAIT_INT then exits after one cycle.
REQ-026 A change on blk_len outside RECORD has no effect on the current block.

Reset
REQ-027 While aclr_n is low: state=INIT; data_cnt, tail_cnt, len_q and the valid shift register are 0; out_valid=0; blk_done=0; ready=1.
REQ-028 Reset asserted mid-block discards the block immediately and asynchronously; the FSM restarts from INIT on the first clock after release.

Configuration
REQ-029 With macro ENC_CTRL_ABORT_EN defined, the block adds input port abort (1 bit):
- abort high in any state other than INIT forces the next state to INIT;
- it also clears data_cnt and tail_cnt;
- blk_done is not pulsed;
- abort has priority over all other transitions;
- the valid shift register drains normally.
REQ-030 With ENC_CTRL_ABORT_EN undefined, there is no abort port and the FSM behaves as specified above.

Verification
REQ-031 blk_len=8, TAIL_LEN=3, out_ready=1 -> enc_en high for 11 consecutive cycles; data_cnt ends at 8; blk_done pulses once, 1 cycle after WAIT_TAIL ends.
REQ-032 Same setup with out_ready low for 4 cycles mid-OPERATE -> state and data_cnt hold; enc_en gaps total 4 cycles; enc_en still high for 11 cycles in total.
REQ-033 blk_len=0 -> treated as 2: exactly 1 OPERATE cycle and 1 LAST_OPERATE cycle.
REQ-034 VALID_DLY=3 -> out_valid rises exactly 3 clocks after enc_en rises and falls exactly 3 clocks after enc_en falls.
REQ-035 aclr_n pulsed low during WAIT_TAIL -> outputs take reset values at once; ready=1; a new block then completes normally.
REQ-036 ENC_CTRL_ABORT_EN defined, abort asserted in OPERATE -> INIT on the next clock; no blk_done pulse; data_cnt=0.
